// File: rtl/n_bit_shift_engine.sv
// Multi-cycle shift/rotate register: moves up to STEP bits per clock until the
// requested distance is covered, with load/zero/nop single-cycle operations.
module n_bit_shift_engine #(
  parameter int unsigned N    = 8,
  parameter int unsigned STEP = 1,
  parameter int unsigned AW   = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  D,
  input  logic          Ds,
  output logic [N-1:0]  Q,
  output logic          busy,
  output logic          done,
  output logic          sout
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SAR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ZERO = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  q_nxt;
  logic          sout_nxt;
  logic [AW-1:0] rem, rem_nxt;
  logic [2:0]    op_q, op_nxt;
  logic          ds_q, ds_nxt;

  int unsigned     k_c;
  logic            fill_c;
  logic [2*N-1:0]  ext_c;
  logic [N-1:0]    step_q_c;
  logic            step_sout_c;

  // One step of k bits: the doubled vector supplies fill/wrap bits to shift in.
  always_comb begin
    k_c         = (32'(rem) > STEP) ? STEP : 32'(rem);
    fill_c      = (op_q == OP_SAR) ? Q[N-1] : ds_q;
    ext_c       = '0;
    step_q_c    = Q;
    step_sout_c = sout;
    case (op_q)
      OP_SHL: begin
        ext_c       = {Q, {N{fill_c}}} << k_c;
        step_q_c    = ext_c[2*N-1:N];
        step_sout_c = |(Q & (N'(1) << (N - k_c)));
      end
      OP_SHR, OP_SAR: begin
        ext_c       = {{N{fill_c}}, Q} >> k_c;
        step_q_c    = ext_c[N-1:0];
        step_sout_c = |(Q & (N'(1) << (k_c - 1)));
      end
      OP_ROL: begin
        ext_c       = {Q, Q} << k_c;
        step_q_c    = ext_c[2*N-1:N];
        step_sout_c = |(Q & (N'(1) << (N - k_c)));
      end
      OP_ROR: begin
        ext_c       = {Q, Q} >> k_c;
        step_q_c    = ext_c[N-1:0];
        step_sout_c = |(Q & (N'(1) << (k_c - 1)));
      end
      default: ;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    sout_nxt  = sout;
    rem_nxt   = rem;
    op_nxt    = op_q;
    ds_nxt    = ds_q;
    case (state)
      SHIFT: begin
        q_nxt    = step_q_c;
        sout_nxt = step_sout_c;
        rem_nxt  = rem - AW'(k_c);
        if (32'(rem) <= STEP) state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
        if (start) begin
          op_nxt = op;
          ds_nxt = Ds;
          case (op)
            OP_LOAD: begin
              q_nxt     = D;
              state_nxt = DONE;
            end
            OP_ZERO: begin
              q_nxt     = '0;
              state_nxt = DONE;
            end
            OP_NOP: state_nxt = DONE;
            default: begin
              if (amt == '0) begin
                state_nxt = DONE;
              end else begin
                rem_nxt   = amt;
                state_nxt = SHIFT;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      Q     <= '0;
      sout  <= 1'b0;
      rem   <= '0;
      op_q  <= OP_NOP;
      ds_q  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Q     <= q_nxt;
      sout  <= sout_nxt;
      rem   <= rem_nxt;
      op_q  <= op_nxt;
      ds_q  <= ds_nxt;
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_n_bit_shift_engine.sv
// Bench for n_bit_shift_engine: bit-at-a-time reference model checked every
// cycle, closed-form final-result checks, directed scenarios and random traffic.
module tb_n_bit_shift_engine;
  localparam int unsigned N    = 8;
  localparam int unsigned STEP = 3;
  localparam int unsigned AW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr, start, ds;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [N-1:0]  d;
  logic [N-1:0]  q;
  logic          busy, done, sout;

  n_bit_shift_engine #(.N(N), .STEP(STEP), .AW(AW)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .amt(amt), .D(d), .Ds(ds),
    .Q(q), .busy(busy), .done(done), .sout(sout)
  );

  int checks = 0;
  int passes = 0;

  // Reference state: 0 idle, 1 shifting, 2 done
  logic [7:0]  m_q;
  logic        m_sout;
  int unsigned m_rem;
  int          m_st;
  logic [2:0]  m_op;
  logic        m_ds;
  logic [7:0]  t_q;
  int unsigned t_amt;
  logic        end_shift;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
  endtask

  // Single-bit move; a k-bit step is k of these in a row.
  function automatic logic [7:0] step1(input logic [2:0] o, input logic [7:0] v,
                                       input logic f, output logic so);
    so = 1'b0;
    step1 = v;
    case (o)
      3'd1: begin so = v[7]; step1 = {v[6:0], f};    end
      3'd2: begin so = v[0]; step1 = {f, v[7:1]};    end
      3'd3: begin so = v[0]; step1 = {v[7], v[7:1]}; end
      3'd4: begin so = v[7]; step1 = {v[6:0], v[7]}; end
      3'd5: begin so = v[0]; step1 = {v[0], v[7:1]}; end
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] kstep(input logic [2:0] o, input logic [7:0] v,
                                       input logic f, input int unsigned k, output logic so);
    logic [7:0] r;
    so = 1'b0;
    r  = v;
    for (int i = 0; i < int'(k); i++) r = step1(o, r, f, so);
    return r;
  endfunction

  // Whole-transaction result from plain arithmetic
  function automatic logic [7:0] closed(input logic [2:0] o, input logic [7:0] v,
                                        input int unsigned a, input logic f);
    logic signed [7:0] s;
    logic [7:0] m;
    int unsigned r;
    r = a % 8;
    s = v;
    case (o)
      3'd1: begin
        if (a >= 8) return {8{f}};
        m = 8'hFF >> (8 - a);
        return (v << a) | (f ? m : 8'h00);
      end
      3'd2: begin
        if (a >= 8) return {8{f}};
        m = 8'hFF >> a;
        return (v >> a) | (f ? ~m : 8'h00);
      end
      3'd3: return 8'(s >>> a);
      3'd4: return (v << r) | (v >> (8 - r));
      3'd5: return (v >> r) | (v << (8 - r));
      default: return v;
    endcase
  endfunction

  task automatic model_update();
    int unsigned k;
    logic so;
    end_shift = 1'b0;
    if (clr) begin
      m_q = 8'h00; m_sout = 1'b0; m_rem = 0; m_st = 0;
    end else if (m_st == 1) begin
      k      = (m_rem < STEP) ? m_rem : STEP;
      m_q    = kstep(m_op, m_q, m_ds, k, so);
      m_sout = so;
      m_rem  = m_rem - k;
      if (m_rem == 0) begin
        m_st = 2;
        end_shift = 1'b1;
      end
    end else begin
      m_st = 0;
      if (start) begin
        m_op = op; m_ds = ds; t_q = m_q; t_amt = int'(amt);
        case (op)
          3'd0: begin m_q = d;     m_st = 2; end
          3'd6: begin m_q = 8'h00; m_st = 2; end
          3'd7: m_st = 2;
          default: begin
            if (amt == 0) m_st = 2;
            else begin m_rem = int'(amt); m_st = 1; end
          end
        endcase
      end
    end
  endtask

  // Advance one clock, update the model, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check("q",    32'(q),    32'(m_q));
    check("busy", 32'(busy), 32'(m_st == 1));
    check("done", 32'(done), 32'(m_st == 2));
    check("sout", 32'(sout), 32'(m_sout));
    if (end_shift) check("final", 32'(q), 32'(closed(m_op, t_q, t_amt, m_ds)));
  endtask

  task automatic req(input logic s, input logic [2:0] o, input logic [AW-1:0] a,
                     input logic [7:0] dd, input logic f);
    start = s; op = o; amt = a; d = dd; ds = f;
  endtask

  initial begin
    logic so;
    logic [7:0] r;
    m_q = 8'h00; m_sout = 1'b0; m_rem = 0; m_st = 0; m_op = 3'd7; m_ds = 1'b0;
    t_q = 8'h00; t_amt = 0; end_shift = 1'b0;
    clr = 1'b1;
    req(1'b0, 3'd7, 4'd0, 8'h00, 1'b0);

    // Pin the model against hand-computed values
    r = kstep(3'd1, 8'hA5, 1'b1, 1, so); check("pin_shl1", 32'({r, so}), 32'({8'h4B, 1'b1}));
    r = kstep(3'd1, r,     1'b1, 1, so); check("pin_shl2", 32'({r, so}), 32'({8'h97, 1'b0}));
    r = kstep(3'd1, r,     1'b1, 1, so); check("pin_shl3", 32'({r, so}), 32'({8'h2F, 1'b1}));
    r = kstep(3'd5, 8'h81, 1'b0, 4, so); r = kstep(3'd5, r, 1'b0, 4, so);
    r = kstep(3'd5, r, 1'b0, 2, so);     check("pin_ror", 32'(r), 32'(8'h60));
    check("pin_closed_ror", 32'(closed(3'd5, 8'h81, 10, 1'b0)), 32'(8'h60));
    check("pin_closed_sar", 32'(closed(3'd3, 8'h90, 5, 1'b0)), 32'(8'hFC));
    check("pin_closed_shl", 32'(closed(3'd1, 8'hA5, 3, 1'b1)), 32'(8'h2F));

    tick(); tick();
    check("rst_q", 32'(q), 32'(8'h00));
    check("rst_flags", 32'({busy, done, sout}), 32'(3'b000));

    clr = 1'b0;
    req(1'b1, 3'd0, 4'd0, 8'hA5, 1'b0); tick();
    check("load_q", 32'(q), 32'(8'hA5));
    check("load_flags", 32'({busy, done}), 32'(2'b01));

    // Back-to-back accepts from DONE, then SAR 0x90 by 5 with STEP=3
    req(1'b1, 3'd0, 4'd0, 8'h90, 1'b0); tick();
    req(1'b1, 3'd3, 4'd5, 8'h00, 1'b0); tick();
    check("sar_acc", 32'({busy, q}), 32'({1'b1, 8'h90}));
    req(1'b0, 3'd7, 4'd0, 8'h00, 1'b0); tick();
    check("sar_s1", 32'({busy, q}), 32'({1'b1, 8'hF2}));
    tick();
    check("sar_s2", 32'({busy, done, sout, q}), 32'({3'b011, 8'hFC}));
    tick();
    check("sar_idle", 32'({busy, done}), 32'(2'b00));

    // Start during SHIFT is ignored
    req(1'b1, 3'd0, 4'd0, 8'h3C, 1'b0); tick();
    req(1'b1, 3'd1, 4'd7, 8'h00, 1'b1); tick();
    req(1'b1, 3'd1, 4'd1, 8'hFF, 1'b0); tick(); tick();
    req(1'b0, 3'd7, 4'd0, 8'h00, 1'b0); tick();
    check("ign_q", 32'({done, q}), 32'({1'b1, 8'h7F}));
    req(1'b1, 3'd2, 4'd0, 8'h00, 1'b0); tick();
    check("amt0", 32'({busy, done, q}), 32'({2'b01, 8'h7F}));

    // clr mid-shift, then a normal LOAD
    req(1'b1, 3'd4, 4'd9, 8'h00, 1'b0); tick();
    req(1'b0, 3'd7, 4'd0, 8'h00, 1'b0); tick();
    clr = 1'b1; tick();
    check("clr_mid", 32'({busy, done, sout, q}), 32'({3'b000, 8'h00}));
    clr = 1'b0;
    req(1'b1, 3'd0, 4'd0, 8'h5A, 1'b0); tick();
    check("post_clr_load", 32'({done, q}), 32'({1'b1, 8'h5A}));
    clr = 1'b1;
    req(1'b1, 3'd0, 4'd0, 8'hFF, 1'b0); tick();
    check("clr_prio", 32'(q), 32'(8'h00));
    clr = 1'b0;

    // Random traffic
    repeat (800) begin
      clr = ($urandom_range(0, 59) == 0);
      req(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
          AW'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
